pio_led_ctrl: RTL

//  Avalon-MM controller that owns the 8-bit LED PIO slave port (regs: 0 data, 1 dir, 2 irq_mask,
//  3 edge_capture, 4 set-bits, 5 clear-bits; readdata registered, 1-cycle latency, no waitrequest).

---
 rtl/pio_led_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pio_led_ctrl.sv
// rtl/pio_led_ctrl.sv - LED PIO master: init sequence, CPU/pattern-engine arbitration, read return
module pio_led_ctrl #(
    parameter int         DIV      = 50_000_000,
    parameter logic [7:0] DIR_INIT = 8'hFF,
    parameter logic [7:0] PAT_INIT = 8'h01,
    parameter int         MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic        mode,
    input  logic        cpu_chipselect,
    input  logic [2:0]  cpu_address,
    input  logic        cpu_write_n,
    input  logic [31:0] cpu_writedata,
    output logic [31:0] cpu_readdata,
    output logic        cpu_waitrequest,
    output logic [2:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata,
    input  logic [31:0] pio_readdata,
    output logic        init_done,
    output logic        overrun
);
    localparam int CW = $clog2(DIV);
    localparam int SW = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {INIT_DIR, INIT_MSK, INIT_DAT, RUN, RD_RET} state_t;

    state_t          state, state_nxt;
    logic [7:0]      pat;
    logic [CW-1:0]   tick_cnt;
    logic            eng_pend;
    logic [SW-1:0]   starve_cnt;
    logic [2:0]      rd_addr;
    logic            gnt_eng;
    logic            rd_capture;
    logic            running;
    logic            tick;
    logic            eng_urgent;

    assign running    = (state == RUN) || (state == RD_RET);
    assign tick       = running && en && (tick_cnt == CW'(DIV - 1));
    assign eng_urgent = eng_pend && (starve_cnt >= SW'(MAX_WAIT));
    assign init_done  = running;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= INIT_DIR;
            pat        <= PAT_INIT;
            tick_cnt   <= '0;
            eng_pend   <= 1'b0;
            starve_cnt <= '0;
            overrun    <= 1'b0;
            rd_addr    <= '0;
        end else begin
            state <= state_nxt;
            if (rd_capture)
                rd_addr <= cpu_address;
            if (running && en)
                tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
            else
                tick_cnt <= '0;
            if (tick)
                pat <= mode ? pat + 8'd1 : {pat[6:0], pat[7]};
            // A tick always wins over a same-cycle grant: the grant carried the old pattern.
            if (tick)
                eng_pend <= 1'b1;
            else if (gnt_eng)
                eng_pend <= 1'b0;
            if (tick && eng_pend && !gnt_eng)
                overrun <= 1'b1;
            if (gnt_eng)
                starve_cnt <= '0;
            else if (eng_pend && (starve_cnt < SW'(MAX_WAIT)))
                starve_cnt <= starve_cnt + SW'(1);
        end
    end

    always_comb begin
        state_nxt       = state;
        gnt_eng         = 1'b0;
        rd_capture      = 1'b0;
        pio_chipselect  = 1'b0;
        pio_write_n     = 1'b1;
        pio_address     = '0;
        pio_writedata   = '0;
        cpu_waitrequest = 1'b1;
        cpu_readdata    = '0;
        case (state)
            INIT_DIR: begin
                pio_chipselect = 1'b1;
                pio_write_n    = 1'b0;
                pio_address    = 3'd1;
                pio_writedata  = {24'b0, DIR_INIT};
                state_nxt      = INIT_MSK;
            end
            INIT_MSK: begin
                pio_chipselect = 1'b1;
                pio_write_n    = 1'b0;
                pio_address    = 3'd2;
                state_nxt      = INIT_DAT;
            end
            INIT_DAT: begin
                pio_chipselect = 1'b1;
                pio_write_n    = 1'b0;
                pio_address    = 3'd0;
                pio_writedata  = {24'b0, pat};
                state_nxt      = RUN;
            end
            RUN: begin
                if (eng_pend && (eng_urgent || !cpu_chipselect)) begin
                    gnt_eng        = 1'b1;
                    pio_chipselect = 1'b1;
                    pio_write_n    = 1'b0;
                    pio_address    = 3'd0;
                    pio_writedata  = {24'b0, pat};
                end else if (cpu_chipselect) begin
                    pio_chipselect = 1'b1;
                    pio_write_n    = cpu_write_n;
                    pio_address    = cpu_address;
                    pio_writedata  = cpu_writedata;
                    if (cpu_write_n) begin
                        rd_capture = 1'b1;
                        state_nxt  = RD_RET;
                    end else begin
                        cpu_waitrequest = 1'b0;
                    end
                end
            end
            RD_RET: begin
                pio_address     = rd_addr;
                cpu_readdata    = pio_readdata;
                cpu_waitrequest = 1'b0;
                state_nxt       = RUN;
            end
            default: state_nxt = INIT_DIR;
        endcase
        // The reset state is INIT_DIR, so its write must be masked while reset is held.
        if (!reset_n) begin
            pio_chipselect  = 1'b0;
            pio_write_n     = 1'b1;
            pio_address     = '0;
            pio_writedata   = '0;
            cpu_waitrequest = 1'b1;
            cpu_readdata    = '0;
        end
    end
endmodule
